pipe_sel_mux: RTL and testbench
===============================

// Module: pipe_sel_mux
// PURPOSE
//  Parametrised N:1 select stage with one registered output and a 1-entry skid buffer.
//  Successor to the 2:1 combinational mux: any input count and width, ready/valid handshake,
//  flush, and out-of-range select detection.
//  Used for registered operand/forwarding selection between pipeline stages, where
//  back-pressure from a stalled stage must not drop a selected word.
// PARAMETERS
//  WIDTH   32  data width of each input word and of the output
//  NUM_IN  4   number of input words (>=2)
//  SEL_W   3   select width; must satisfy 2**SEL_W >= NUM_IN; codes >= NUM_IN are illegal
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             synchronous active-low reset
//  in_data    in   NUM_IN*WIDTH  packed inputs; word i = in_data[i*WIDTH +: WIDTH]
//  sel        in   SEL_W         binary select, sampled with the input beat
//  in_valid   in   1             input beat present
//  in_ready   out  1             stage can accept a beat
//  flush      in   1             discard all held beats (pipeline squash)
//  out_data   out  WIDTH         selected word (registered)
//  out_sel    out  SEL_W         select code that produced out_data
//  out_valid  out  1             out_data valid
//  out_ready  in   1             downstream accepts out_data
//  sel_err    out  1             sticky: an accepted beat carried sel >= NUM_IN
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_sel=0, skid empty,
//    in_ready=1, sel_err=0. Reset overrides flush and all handshakes.
//  - Accept = in_valid & in_ready. Take = out_valid & out_ready.
//  - Selected word = in_data[sel*WIDTH +: WIDTH] if sel<NUM_IN, else all-zero.
//    An accepted illegal sel sets sel_err; the zero word still propagates with out_sel=sel.
//    sel_err is cleared only by reset.
//  - Latency: accepted beat appears on out_* the next cycle if the output reg is free or being taken.
//  - in_ready = !skid_valid (registered; no combinational path from out_ready).
//  - Occupancy states: EMPTY (out 0, skid 0), ONE (out 1, skid 0), FULL (out 1, skid 1).
//    EMPTY: accept -> ONE. Otherwise stay.
//    ONE: accept & take -> ONE with new word. Accept & !take -> FULL (new word into skid).
//         !accept & take -> EMPTY. Otherwise stay.
//    FULL: in_ready=0. Take -> ONE (skid moves to out reg). !take -> hold both, unchanged.
//  - Order is strictly preserved: the skid word always leaves before any later beat.
//  - out_data/out_sel hold stable while out_valid & !out_ready.
//  - flush=1: next cycle EMPTY (out_valid=0, skid cleared). A beat accepted in the flush cycle
//    is dropped, and its sel is not checked for sel_err. Take in the flush cycle completes normally.
//  - out_data is not cleared on flush or drain; only out_valid qualifies it.
// STRUCTURE
//  - Shared package mux_pkg: occupancy state enum {EMPTY, ONE, FULL}; localparam
//    function for the minimum SEL_W (clog2).
//  - One combinational sub-module mux_sel (WIDTH, NUM_IN, SEL_W): N:1 word select plus an
//    out-of-range flag. Instantiated once, on the input path.
//  - Top level holds the out register, the skid register, the state and sel_err.
//  - Elaboration check: error if NUM_IN<2 or 2**SEL_W<NUM_IN.
// TESTING
//  1. Reset mid-stream: in FULL, pulse rst_n=0 for one cycle -> out_valid=0, in_ready=1,
//     sel_err=0 next cycle.
//  2. Streaming: out_ready=1; send sel=0,1,2,3 with word i=32'h1000_0000+i every cycle
//     -> out_data 32'h1000_0000..32'h1000_0003 in order, 1-cycle latency, in_ready stays 1.
//  3. Back-pressure: out_ready=0; send A (sel=2) then B (sel=1) -> out=A, skid=B, in_ready=0.
//     Raise out_ready -> A, then B, on consecutive cycles; nothing lost or duplicated.
//  4. Illegal select: accept sel=3'd5 with NUM_IN=4 -> out_data=0, out_sel=5, sel_err=1,
//     and sel_err stays 1 through 10 further legal beats.
//  5. Flush: in FULL, assert flush together with an in_valid beat -> next cycle out_valid=0,
//     in_ready=1, the beat is dropped.
//  6. Corners: sweep NUM_IN=2/WIDTH=8/SEL_W=1 and NUM_IN=5/SEL_W=3 with random valid/ready
//     -> scoreboard matches the reference model.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the pipe_sel_mux select stage.
//   occ_state_e  : occupancy of the output register / skid buffer pair
//   min_sel_w()  : smallest select width able to address n inputs
// -----------------------------------------------------------------------------
package mux_pkg;

    // Occupancy of the stage:
    //   ST_EMPTY : output register empty, skid empty
    //   ST_ONE   : output register holds a word, skid empty
    //   ST_FULL  : output register and skid both hold a word
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    // Minimum select width that can encode n distinct inputs (never below 1).
    function automatic int min_sel_w(input int n);
        int w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage : mux_pkg

// File: rtl/mux_sel.sv
// -----------------------------------------------------------------------------
// mux_sel
// Combinational N:1 word selector with an out-of-range flag.
//   in_data  in   NUM_IN*WIDTH  packed words, word i = in_data[i*WIDTH +: WIDTH]
//   sel      in   SEL_W         binary select code
//   word     out  WIDTH         selected word, all-zero for an illegal code
//   illegal  out  1             sel does not address any input (sel >= NUM_IN)
// -----------------------------------------------------------------------------
module mux_sel
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 3
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        word,
    output logic                    illegal
);

    // One-hot style scan: a code that matches no input leaves the zero word
    // and the illegal flag set, so illegal codes need no separate compare.
    always_comb begin
        word    = '0;
        illegal = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            word    = (sel == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : word;
            illegal = (sel == SEL_W'(i)) ? 1'b0 : illegal;
        end
    end

endmodule : mux_sel

// File: rtl/pipe_sel_mux.sv
// -----------------------------------------------------------------------------
// pipe_sel_mux
// Registered N:1 select stage with a one-entry skid buffer, ready/valid on both
// sides, pipeline flush and sticky detection of illegal select codes.
//   clk        in   1             rising-edge clock
//   rst_n      in   1             synchronous active-low reset
//   in_data    in   NUM_IN*WIDTH  packed input words
//   sel        in   SEL_W         select code, sampled with the input beat
//   in_valid   in   1             input beat present
//   in_ready   out  1             stage can accept a beat (registered)
//   flush      in   1             squash every held beat
//   out_data   out  WIDTH         selected word (registered)
//   out_sel    out  SEL_W         select code that produced out_data
//   out_valid  out  1             out_data valid
//   out_ready  in   1             downstream accepts out_data
//   sel_err    out  1             sticky: an accepted beat carried an illegal sel
// -----------------------------------------------------------------------------
module pipe_sel_mux
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    // Reject parameter sets the select path cannot represent.
    if (NUM_IN < 2) begin : g_bad_num_in
        $error("pipe_sel_mux: NUM_IN must be at least 2");
    end
    if ((SEL_W < min_sel_w(NUM_IN)) || ((2 ** SEL_W) < NUM_IN)) begin : g_bad_sel_w
        $error("pipe_sel_mux: SEL_W too narrow for NUM_IN");
    end

    // Registered state
    occ_state_e         state_r;
    logic               out_valid_r;
    logic               in_ready_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [SEL_W-1:0]   out_sel_r;
    logic [WIDTH-1:0]   skid_data_r;
    logic [SEL_W-1:0]   skid_sel_r;
    logic               sel_err_r;

    // Combinational control
    occ_state_e         next_state_s;
    logic               accept_s;
    logic               take_s;
    logic               load_out_in_s;
    logic               load_out_skid_s;
    logic               load_skid_s;
    logic               set_err_s;
    logic [WIDTH-1:0]   sel_word_s;
    logic               sel_illegal_s;

    mux_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux_sel (
        .in_data (in_data),
        .sel     (sel),
        .word    (sel_word_s),
        .illegal (sel_illegal_s)
    );

    assign accept_s = in_valid & in_ready_r;
    assign take_s   = out_valid_r & out_ready;

    // Next-state and register-load decode for the occupancy FSM.
    always_comb begin
        next_state_s    = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        set_err_s       = 1'b0;

        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    next_state_s  = ST_ONE;
                    load_out_in_s = 1'b1;
                end else begin
                    next_state_s  = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && take_s) begin
                    next_state_s  = ST_ONE;
                    load_out_in_s = 1'b1;
                end else if (accept_s) begin
                    // Output is stalled: park the new word in the skid.
                    next_state_s  = ST_FULL;
                    load_skid_s   = 1'b1;
                end else if (take_s) begin
                    next_state_s  = ST_EMPTY;
                end else begin
                    next_state_s  = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the skid can move forward.
                if (take_s) begin
                    next_state_s    = ST_ONE;
                    load_out_skid_s = 1'b1;
                end else begin
                    next_state_s    = ST_FULL;
                end
            end
            default: begin
                next_state_s = ST_EMPTY;
            end
        endcase

        // Only beats that really enter the stage are checked for sel_err.
        set_err_s = accept_s & sel_illegal_s;

        // Flush squashes everything; a take in this cycle has already
        // completed from the downstream point of view. Data registers keep
        // their contents because out_valid alone qualifies them.
        if (flush) begin
            next_state_s    = ST_EMPTY;
            load_out_in_s   = 1'b0;
            load_out_skid_s = 1'b0;
            load_skid_s     = 1'b0;
            set_err_s       = 1'b0;
        end else begin
            next_state_s    = next_state_s;
        end
    end

    // State, handshake flags, data registers and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_data_r  <= '0;
            out_sel_r   <= '0;
            skid_data_r <= '0;
            skid_sel_r  <= '0;
            sel_err_r   <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            // Flags are registered from the next state so neither output
            // depends combinationally on out_ready.
            out_valid_r <= (next_state_s != ST_EMPTY);
            in_ready_r  <= (next_state_s != ST_FULL);

            if (load_out_in_s) begin
                out_data_r <= sel_word_s;
                out_sel_r  <= sel;
            end else if (load_out_skid_s) begin
                out_data_r <= skid_data_r;
                out_sel_r  <= skid_sel_r;
            end else begin
                out_data_r <= out_data_r;
                out_sel_r  <= out_sel_r;
            end

            if (load_skid_s) begin
                skid_data_r <= sel_word_s;
                skid_sel_r  <= sel;
            end else begin
                skid_data_r <= skid_data_r;
                skid_sel_r  <= skid_sel_r;
            end

            if (set_err_s) begin
                sel_err_r <= 1'b1;
            end else begin
                sel_err_r <= sel_err_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
    assign sel_err   = sel_err_r;

endmodule : pipe_sel_mux

// File: tb/tb_pipe_sel_mux.sv
// -----------------------------------------------------------------------------
// tb_pipe_sel_mux
// Scoreboard bench: the driver pushes the hand-computed word for every beat the
// stage accepts; per-DUT monitors compare the head of the queue whenever a
// DUT shows out_valid and pop it when the word is taken. Two extra instances
// cover the NUM_IN=2/WIDTH=8/SEL_W=1 and NUM_IN=5/SEL_W=3 corners.
// -----------------------------------------------------------------------------
module tb_pipe_sel_mux;

    localparam int W = 32;
    localparam int N = 4;
    localparam int S = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [N*W-1:0]     in_data;
    logic [S-1:0]       sel;
    logic               in_valid, in_ready, flush;
    logic [W-1:0]       out_data;
    logic [S-1:0]       out_sel;
    logic               out_valid, out_ready, sel_err;

    // Corner instance A: NUM_IN=2, WIDTH=8, SEL_W=1
    logic [15:0]        c2_in_data;
    logic [0:0]         c2_sel;
    logic               c2_in_valid, c2_in_ready, c2_flush;
    logic [7:0]         c2_out_data;
    logic [0:0]         c2_out_sel;
    logic               c2_out_valid, c2_out_ready, c2_sel_err;

    // Corner instance B: NUM_IN=5, WIDTH=32, SEL_W=3
    logic [159:0]       c5_in_data;
    logic [2:0]         c5_sel;
    logic               c5_in_valid, c5_in_ready, c5_flush;
    logic [31:0]        c5_out_data;
    logic [2:0]         c5_out_sel;
    logic               c5_out_valid, c5_out_ready, c5_sel_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [2:0] s; logic [31:0] d; } exp_t;
    typedef struct packed { logic [0:0] s; logic [7:0]  d; } exp2_t;
    exp_t  q[$];
    exp2_t q2[$];
    exp_t  q5[$];
    logic  err5 = 1'b0;

    pipe_sel_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    pipe_sel_mux #(.WIDTH(8), .NUM_IN(2), .SEL_W(1)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_data(c2_in_data), .sel(c2_sel),
        .in_valid(c2_in_valid), .in_ready(c2_in_ready), .flush(c2_flush),
        .out_data(c2_out_data), .out_sel(c2_out_sel), .out_valid(c2_out_valid),
        .out_ready(c2_out_ready), .sel_err(c2_sel_err)
    );

    pipe_sel_mux #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) dut_c5 (
        .clk(clk), .rst_n(rst_n), .in_data(c5_in_data), .sel(c5_sel),
        .in_valid(c5_in_valid), .in_ready(c5_in_ready), .flush(c5_flush),
        .out_data(c5_out_data), .out_sel(c5_out_sel), .out_valid(c5_out_valid),
        .out_ready(c5_out_ready), .sel_err(c5_sel_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Main monitor: head of queue must be on the output while out_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL main_unexpected: got out_data %0h, expected no valid output", out_data);
                end else begin
                    check("main_data", 64'(out_data), 64'(q[0].d));
                    check("main_sel", 64'(out_sel), 64'(q[0].s));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    // Corner A monitor.
    always @(negedge clk) begin
        if (rst_n && c2_out_valid) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL c2_unexpected: got out_data %0h, expected no valid output", c2_out_data);
            end else begin
                check("c2_data", 64'(c2_out_data), 64'(q2[0].d));
                check("c2_sel", 64'(c2_out_sel), 64'(q2[0].s));
                if (c2_out_ready) void'(q2.pop_front());
            end
        end
    end

    // Corner B monitor, including the sticky error model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("c5_sel_err", 64'(c5_sel_err), 64'(err5));
            if (c5_out_valid) begin
                if (q5.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL c5_unexpected: got out_data %0h, expected no valid output", c5_out_data);
                end else begin
                    check("c5_data", 64'(c5_out_data), 64'(q5[0].d));
                    check("c5_sel", 64'(c5_out_sel), 64'(q5[0].s));
                    if (c5_out_ready) void'(q5.pop_front());
                end
            end
        end
    end

    function automatic logic [N*W-1:0] dvec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = 32'h1000_0000 + 32'(i);
        return v;
    endfunction

    // One cycle on the main DUT; expw is the hand-computed word for sel s.
    task automatic drive(input logic v, input logic [2:0] s, input logic ordy,
                         input logic fl, input logic [31:0] expw);
        logic acc;
        in_valid  = v;
        sel       = s;
        in_data   = dvec();
        out_ready = ordy;
        flush     = fl;
        acc = v && in_ready && !fl && rst_n;
        @(posedge clk);
        #2;
        if (fl) q.delete();
        if (acc) q.push_back('{s: s, d: expw});
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; sel = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        c2_in_valid = 1'b0; c2_sel = '0; c2_in_data = '0; c2_flush = 1'b0; c2_out_ready = 1'b0;
        c5_in_valid = 1'b0; c5_sel = '0; c5_in_data = '0; c5_flush = 1'b0; c5_out_ready = 1'b0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_sel_err", 64'(sel_err), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sel", 64'(out_sel), 64'd0);
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);

        // Streaming: sel 0..3, one per cycle, downstream always ready
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i), 1'b1, 1'b0, 32'h1000_0000 + 32'(i));
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        check("stream_last", 64'(out_data), 64'h1000_0003);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
        check("stream_drained", 64'(out_valid), 64'd0);

        // Back-pressure: A (sel 2) then B (sel 1) with out_ready low
        drive(1'b1, 3'd2, 1'b0, 1'b0, 32'h1000_0002);
        drive(1'b1, 3'd1, 1'b0, 1'b0, 32'h1000_0001);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_a", 64'(out_data), 64'h1000_0002);
        // Beat offered while full must not be taken
        drive(1'b1, 3'd3, 1'b0, 1'b0, 32'h1000_0003);
        check("bp_hold_a", 64'(out_data), 64'h1000_0002);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
        check("bp_out_b", 64'(out_data), 64'h1000_0001);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
        check("bp_empty", 64'(out_valid), 64'd0);
        check("bp_queue", 64'(q.size()), 64'd0);

        // Illegal select, then ten legal beats with sel_err held
        drive(1'b1, 3'd5, 1'b1, 1'b0, 32'd0);
        check("ill_data", 64'(out_data), 64'd0);
        check("ill_sel", 64'(out_sel), 64'd5);
        check("ill_err", 64'(sel_err), 64'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'(i % 4), 1'b1, 1'b0, 32'h1000_0000 + 32'(i % 4));
            check("ill_err_sticky", 64'(sel_err), 64'd1);
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);

        // Reset in FULL
        drive(1'b1, 3'd0, 1'b0, 1'b0, 32'h1000_0000);
        drive(1'b1, 3'd3, 1'b0, 1'b0, 32'h1000_0003);
        check("full_before_rst", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
        q.delete();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_sel_err", 64'(sel_err), 64'd0);
        rst_n = 1'b1;

        // Flush in FULL together with an offered beat
        drive(1'b1, 3'd1, 1'b0, 1'b0, 32'h1000_0001);
        drive(1'b1, 3'd2, 1'b0, 1'b0, 32'h1000_0002);
        drive(1'b1, 3'd3, 1'b0, 1'b1, 32'h1000_0003);
        check("flush_full_valid", 64'(out_valid), 64'd0);
        check("flush_full_in_ready", 64'(in_ready), 64'd1);
        // Flush in ONE with an accepted illegal beat: dropped, no sel_err
        drive(1'b1, 3'd0, 1'b0, 1'b0, 32'h1000_0000);
        drive(1'b1, 3'd6, 1'b0, 1'b1, 32'd0);
        check("flush_one_valid", 64'(out_valid), 64'd0);
        check("flush_no_err", 64'(sel_err), 64'd0);
        // Flush with a take in the same cycle
        drive(1'b1, 3'd2, 1'b0, 1'b0, 32'h1000_0002);
        drive(1'b0, 3'd0, 1'b1, 1'b1, 32'd0);
        check("flush_take_valid", 64'(out_valid), 64'd0);
        // Normal operation resumes
        drive(1'b1, 3'd3, 1'b1, 1'b0, 32'h1000_0003);
        check("post_flush_data", 64'(out_data), 64'h1000_0003);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
        check("main_queue_empty", 64'(q.size()), 64'd0);

        // Corner sweep with random valid/ready
        for (int k = 0; k < 400; k++) begin
            logic acc2, acc5;
            logic [7:0]  e2;
            logic [31:0] e5;
            c2_in_valid  = 1'($urandom_range(0, 1));
            c2_sel       = 1'($urandom_range(0, 1));
            c2_in_data   = 16'($urandom);
            c2_out_ready = ($urandom_range(0, 3) != 0);
            c5_in_valid  = 1'($urandom_range(0, 1));
            c5_sel       = 3'($urandom_range(0, 7));
            for (int j = 0; j < 5; j++) c5_in_data[j*32 +: 32] = $urandom;
            c5_out_ready = ($urandom_range(0, 3) != 0);
            acc2 = c2_in_valid && c2_in_ready;
            acc5 = c5_in_valid && c5_in_ready;
            e2 = c2_in_data[c2_sel*8 +: 8];
            e5 = (c5_sel < 3'd5) ? c5_in_data[c5_sel*32 +: 32] : 32'd0;
            @(posedge clk);
            #2;
            if (acc2) q2.push_back('{s: c2_sel, d: e2});
            if (acc5) q5.push_back('{s: c5_sel, d: e5});
            if (acc5 && (c5_sel >= 3'd5)) err5 = 1'b1;
        end
        c2_in_valid = 1'b0; c2_out_ready = 1'b1;
        c5_in_valid = 1'b0; c5_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("c2_queue_empty", 64'(q2.size()), 64'd0);
        check("c5_queue_empty", 64'(q5.size()), 64'd0);
        check("c2_sel_err", 64'(c2_sel_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipe_sel_mux
